// File: rtl/mini_core_wb_ldq.sv
`default_nettype none
// ============================================================================
// mini_core_wb_ldq : write-back stage with an in-order pending-load queue
// Revision: 1.0
// ============================================================================

package mini_core_wb_ldq_pkg;
    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_PC4  = 2'd1,
        WB_RSV2 = 2'd2,
        WB_RSV3 = 2'd3
    } t_wb_sel;
endpackage

module mini_core_wb_ldq
    import mini_core_wb_ldq_pkg::*;
#(
    parameter  int XLEN     = 32,
    parameter  int DEPTH    = 4,
    parameter  int NUM_REGS = 32,
    localparam int NB       = XLEN / 8,
    localparam int RW       = $clog2(NUM_REGS),
    localparam int OW       = $clog2(NB)
) (
    input  logic                Clock,
    input  logic                Rst,
    input  logic                LdIssueValidQ103H,
    input  logic [RW-1:0]       LdIssueRdQ103H,
    input  logic [NB-1:0]       LdIssueByteEnQ103H,
    input  logic                LdIssueSignExtQ103H,
    input  logic [OW-1:0]       LdIssueOffsetQ103H,
    output logic                LdIssueReadyQ103H,
    input  logic                DMemRspValidQ104H,
    input  logic [XLEN-1:0]     DMemRspDataQ104H,
    input  logic                PipeWbValidQ104H,
    input  logic [RW-1:0]       PipeWbRdQ104H,
    input  t_wb_sel             PipeWbSelQ104H,
    input  logic [XLEN-1:0]     AluOutQ104H,
    input  logic [XLEN-1:0]     PcPlus4Q104H,
    output logic                PipeWbStallQ104H,
    output logic                RegWrEnQ105H,
    output logic [RW-1:0]       RegWrRdQ105H,
    output logic [XLEN-1:0]     RegWrDataQ105H,
    output logic [NUM_REGS-1:0] PendingRdMaskQ103H,
    output logic                LdRspErrQ105H
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [RW-1:0]   r_q_rd  [DEPTH];
    logic [NB-1:0]   r_q_be  [DEPTH];
    logic            r_q_sx  [DEPTH];
    logic [OW-1:0]   r_q_off [DEPTH];
    logic [PW-1:0]   r_rd_ptr;
    logic [PW-1:0]   r_wr_ptr;
    logic [CW-1:0]   r_count;

    logic            r_wr_en;
    logic [RW-1:0]   r_wr_rd;
    logic [XLEN-1:0] r_wr_data;
    logic            r_err;

    logic            w_full;
    logic            w_push;
    logic            w_pop;
    logic            w_stray;
    logic [RW-1:0]   w_head_rd;
    logic [NB-1:0]   w_head_be;
    logic            w_head_sx;
    logic [OW-1:0]   w_head_off;
    logic [XLEN-1:0] w_shifted;
    logic            w_sign;
    logic [XLEN-1:0] w_ld_data;
    logic [XLEN-1:0] w_pipe_data;
    logic [RW-1:0]   w_wr_rd;
    logic [XLEN-1:0] w_wr_data;
    logic            w_wr_en;
    logic [NUM_REGS-1:0] w_mask;
    logic [PW-1:0]   w_rel;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_push  = LdIssueValidQ103H & ~w_full;
    assign w_pop   = DMemRspValidQ104H & (r_count != '0);
    assign w_stray = DMemRspValidQ104H & (r_count == '0);

    always_ff @(posedge Clock or negedge Rst) begin
        if (!Rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload needs no reset: only entries inside [rd_ptr, rd_ptr+count) are ever read.
    always_ff @(posedge Clock) begin
        if (w_push) begin
            r_q_rd[r_wr_ptr]  <= LdIssueRdQ103H;
            r_q_be[r_wr_ptr]  <= LdIssueByteEnQ103H;
            r_q_sx[r_wr_ptr]  <= LdIssueSignExtQ103H;
            r_q_off[r_wr_ptr] <= LdIssueOffsetQ103H;
        end
    end

    assign w_head_rd  = r_q_rd[r_rd_ptr];
    assign w_head_be  = r_q_be[r_rd_ptr];
    assign w_head_sx  = r_q_sx[r_rd_ptr];
    assign w_head_off = r_q_off[r_rd_ptr];
    assign w_shifted  = DMemRspDataQ104H >> {w_head_off, 3'b000};

    // Byte enables are LSB-contiguous, so the last enabled byte holds the sign.
    always_comb begin
        w_sign    = 1'b0;
        w_ld_data = '0;
        for (int i = 0; i < NB; i++) begin
            if (w_head_be[i]) w_sign = w_shifted[8*i+7];
        end
        for (int i = 0; i < NB; i++) begin
            w_ld_data[8*i +: 8] = w_head_be[i] ? w_shifted[8*i +: 8]
                                : (w_head_sx ? {8{w_sign}} : 8'h00);
        end
    end

    always_comb begin
        case (PipeWbSelQ104H)
            WB_ALU:  w_pipe_data = AluOutQ104H;
            WB_PC4:  w_pipe_data = PcPlus4Q104H;
            default: w_pipe_data = '0;
        endcase
    end

    assign w_wr_rd   = w_pop ? w_head_rd : PipeWbRdQ104H;
    assign w_wr_data = w_pop ? w_ld_data : w_pipe_data;
    assign w_wr_en   = (w_pop | PipeWbValidQ104H) & (w_wr_rd != '0);

    always_ff @(posedge Clock or negedge Rst) begin
        if (!Rst) begin
            r_wr_en   <= 1'b0;
            r_wr_rd   <= '0;
            r_wr_data <= '0;
            r_err     <= 1'b0;
        end else begin
            r_wr_en <= w_wr_en;
            r_err   <= w_stray;
            if (w_wr_en) begin
                r_wr_rd   <= w_wr_rd;
                r_wr_data <= w_wr_data;
            end
        end
    end

    always_comb begin
        w_mask = '0;
        w_rel  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_rel = PW'(i) - r_rd_ptr;
            if ({1'b0, w_rel} < r_count) w_mask[r_q_rd[i]] = 1'b1;
        end
        w_mask[0] = 1'b0;
    end

    assign LdIssueReadyQ103H  = ~w_full;
    assign PipeWbStallQ104H   = w_pop & PipeWbValidQ104H;
    assign RegWrEnQ105H       = r_wr_en;
    assign RegWrRdQ105H       = r_wr_rd;
    assign RegWrDataQ105H     = r_wr_data;
    assign PendingRdMaskQ103H = w_mask;
    assign LdRspErrQ105H      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mini_core_wb_ldq.sv
`default_nettype none
// ============================================================================
// tb_mini_core_wb_ldq : directed + randomized bench with a queue-based model
// Revision: 1.0
// ============================================================================
module tb_mini_core_wb_ldq;
    import mini_core_wb_ldq_pkg::*;

    localparam int XLEN = 32, DEPTH = 4, NUM_REGS = 32, NB = 4, RW = 5, OW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                iss_v, iss_sx, ready, rsp_v, wb_v, stall, wr_en, err;
    logic [RW-1:0]       iss_rd, wb_rd, wr_rd;
    logic [NB-1:0]       iss_be;
    logic [OW-1:0]       iss_off;
    logic [XLEN-1:0]     rsp_data, alu, pc4, wr_data;
    t_wb_sel             sel;
    logic [NUM_REGS-1:0] mask;

    mini_core_wb_ldq #(.XLEN(XLEN), .DEPTH(DEPTH), .NUM_REGS(NUM_REGS)) dut (
        .Clock(clk), .Rst(rst_n),
        .LdIssueValidQ103H(iss_v), .LdIssueRdQ103H(iss_rd), .LdIssueByteEnQ103H(iss_be),
        .LdIssueSignExtQ103H(iss_sx), .LdIssueOffsetQ103H(iss_off), .LdIssueReadyQ103H(ready),
        .DMemRspValidQ104H(rsp_v), .DMemRspDataQ104H(rsp_data),
        .PipeWbValidQ104H(wb_v), .PipeWbRdQ104H(wb_rd), .PipeWbSelQ104H(sel),
        .AluOutQ104H(alu), .PcPlus4Q104H(pc4), .PipeWbStallQ104H(stall),
        .RegWrEnQ105H(wr_en), .RegWrRdQ105H(wr_rd), .RegWrDataQ105H(wr_data),
        .PendingRdMaskQ103H(mask), .LdRspErrQ105H(err)
    );

    typedef struct packed {
        logic [RW-1:0] rd;
        logic [NB-1:0] be;
        logic          sx;
        logic [OW-1:0] off;
    } ld_t;

    ld_t             q[$];
    logic            exp_en, exp_err;
    logic [RW-1:0]   exp_rd;
    logic [XLEN-1:0] exp_data;
    int              n_total = 0;
    int              n_bad   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Keep popcount(be) bytes starting at the offset, then extend from the top kept bit.
    function automatic logic [XLEN-1:0] ld_result(input ld_t e, input logic [XLEN-1:0] w);
        int n;
        logic [XLEN-1:0] s, m;
        n = $countones(e.be);
        s = w >> (8 * e.off);
        if (n == NB) return s;
        m = (XLEN'(1) << (8 * n)) - 1;
        s = s & m;
        if (e.sx && n > 0 && s[8*n-1]) s = s | ~m;
        return s;
    endfunction

    function automatic logic [NUM_REGS-1:0] model_mask();
        logic [NUM_REGS-1:0] m = '0;
        foreach (q[i]) m[q[i].rd] = 1'b1;
        m[0] = 1'b0;
        return m;
    endfunction

    task automatic cycle();
        logic pop, push;
        ld_t  e;
        #1;
        check_eq("ready", ready, q.size() != DEPTH);
        check_eq("mask", mask, model_mask());
        pop  = rsp_v && q.size() != 0;
        push = iss_v && q.size() != DEPTH;
        check_eq("stall", stall, pop && wb_v);
        exp_err = rsp_v && q.size() == 0;
        exp_en  = 1'b0;
        if (pop) begin
            e = q.pop_front();
            if (e.rd != 0) begin
                exp_en = 1'b1; exp_rd = e.rd; exp_data = ld_result(e, rsp_data);
            end
        end else if (wb_v && wb_rd != 0) begin
            exp_en = 1'b1; exp_rd = wb_rd;
            exp_data = (sel == WB_ALU) ? alu : (sel == WB_PC4) ? pc4 : '0;
        end
        if (push) q.push_back('{rd: iss_rd, be: iss_be, sx: iss_sx, off: iss_off});
        @(posedge clk);
        #1;
        check_eq("wr_en", wr_en, exp_en);
        check_eq("err", err, exp_err);
        check_eq("wr_rd", wr_rd, exp_rd);
        check_eq("wr_data", wr_data, exp_data);
    endtask

    task automatic idle();
        iss_v = 0; iss_rd = '0; iss_be = '0; iss_sx = 0; iss_off = '0;
        rsp_v = 0; rsp_data = '0;
        wb_v = 0; wb_rd = '0; sel = WB_ALU; alu = '0; pc4 = '0;
    endtask

    task automatic issue(input logic [RW-1:0] rd, input logic [NB-1:0] be,
                         input logic sx, input logic [OW-1:0] off);
        iss_v = 1; iss_rd = rd; iss_be = be; iss_sx = sx; iss_off = off;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        #1;
        q.delete();
        exp_rd = '0; exp_data = '0;
        check_eq("rst_wr_en", wr_en, 0);
        check_eq("rst_wr_rd", wr_rd, 0);
        check_eq("rst_wr_data", wr_data, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_mask", mask, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("rst_ready", ready, 1);
    endtask

    initial begin
        logic [NB-1:0] be_tab [3];
        int k;
        be_tab[0] = 4'h1; be_tab[1] = 4'h3; be_tab[2] = 4'hF;
        idle();
        exp_rd = '0; exp_data = '0;
        do_reset();

        // LW rd5, response two cycles later
        issue(5, 4'hF, 0, 0); cycle();
        idle(); cycle();
        check_eq("t1_mask5", mask[5], 1);
        rsp_v = 1; rsp_data = 32'hDEADBEEF; cycle();
        check_eq("t1_data", wr_data, 32'hDEADBEEF);
        check_eq("t1_rd", wr_rd, 5);
        idle(); cycle();

        // LB sign-extend, LHU zero-extend
        issue(3, 4'h1, 1, 2); cycle();
        idle(); rsp_v = 1; rsp_data = 32'h0080_0000; cycle();
        check_eq("t2_lb", wr_data, 32'hFFFF_FF80);
        idle(); issue(4, 4'h3, 0, 2); cycle();
        idle(); rsp_v = 1; rsp_data = 32'h8001_0000; cycle();
        check_eq("t2_lhu", wr_data, 32'h0000_8001);
        idle();

        // fill, push while full, push+pop, wrap
        for (int i = 0; i < 5; i++) begin issue(RW'(10 + i), 4'hF, 0, 0); cycle(); end
        check_eq("t3_full", ready, 0);
        for (int i = 0; i < 12; i++) begin
            issue(RW'(16 + i), 4'hF, 0, 0);
            rsp_v = 1; rsp_data = 32'h1000 + i;
            cycle();
        end
        idle(); rsp_v = 1;
        for (int i = 0; i < 4; i++) begin rsp_data = $urandom; cycle(); end
        idle();

        // load return beats pipe write-back
        issue(8, 4'hF, 0, 0); cycle();
        idle(); rsp_v = 1; rsp_data = 32'hCAFE; wb_v = 1; wb_rd = 7; sel = WB_ALU; alu = 32'h1234;
        #1; check_eq("t4_stall", stall, 1);
        cycle();
        rsp_v = 0; cycle();
        check_eq("t4_rd", wr_rd, 7);
        check_eq("t4_data", wr_data, 32'h1234);
        idle();

        // stray response, load to rd0
        rsp_v = 1; rsp_data = 32'h55; cycle();
        check_eq("t5_err", err, 1);
        idle(); issue(0, 4'hF, 0, 0); cycle();
        idle(); rsp_v = 1; rsp_data = 32'h77; cycle();
        check_eq("t5_rd0_en", wr_en, 0);
        idle();

        // reset with loads pending
        for (int i = 0; i < 3; i++) begin issue(RW'(20 + i), 4'hF, 0, 0); cycle(); end
        idle(); cycle();
        do_reset();
        rsp_v = 1; rsp_data = 32'h99; cycle();
        check_eq("t6_err", err, 1);
        idle();

        // randomized traffic
        for (int n = 0; n < 800; n++) begin
            iss_v = ($urandom_range(0, 99) < 55);
            iss_rd = RW'($urandom_range(0, NUM_REGS - 1));
            k = $urandom_range(0, 2);
            iss_be = be_tab[k];
            iss_off = (k == 0) ? OW'($urandom_range(0, 3)) : (k == 1) ? OW'($urandom_range(0, 2)) : '0;
            iss_sx = 1'($urandom_range(0, 1));
            rsp_v = ($urandom_range(0, 99) < 45);
            rsp_data = $urandom;
            wb_v = 1'($urandom_range(0, 1));
            wb_rd = RW'($urandom_range(0, NUM_REGS - 1));
            sel = t_wb_sel'($urandom_range(0, 3));
            alu = $urandom;
            pc4 = $urandom;
            cycle();
            if (n == 400) do_reset();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
